cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 The block SHALL have no parameters: 16 B lines, 8 words of 16 bits, 16-bit byte addresses.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 miss_detected  in  1  cache lookup missed this cycle.
REQ-005 miss_address  in  16  byte address of the missing access.
REQ-006 mem_data_valid  in  1  memory returns one word this cycle.
REQ-007 mem_data_in  in  16  returned word.
REQ-008 fsm_busy  out  1  fill in progress; stalls the pipeline.
REQ-009 mem_req  out  1  memory read request this cycle.
REQ-010 mem_addr  out  16  byte address of the request.
REQ-011 write_data_array  out  1  data-array word write strobe.
REQ-012 cache_wr_addr  out  16  byte address of the word being written.
REQ-013 cache_wr_data  out  16  word being written.
REQ-014 write_tag_array  out  1  one-cycle metadata (tag/valid) write strobe.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, FILL, TAG.
REQ-016 In IDLE, miss_detected=1 SHALL latch base={miss_address[15:4],4'h0}, clear issue_cnt and rcv_cnt (3-bit each, plus done flags), and enter FILL on the next edge.
REQ-017 In FILL, mem_req SHALL be 1 for exactly 8 consecutive cycles, starting the first FILL cycle.
REQ-018 During those 8 cycles, mem_addr SHALL be base+2*issue_cnt, word order 0..7, with no wrap into the next line.
REQ-019 mem_req SHALL be 0 and mem_addr SHALL hold base when not issuing.
REQ-020 Return latency SHALL be unconstrained; the block SHALL count mem_data_valid pulses and not cycles.
REQ-021 Returns SHALL be in issue order, and valid MAY coincide with an issue cycle.
REQ-022 In FILL, each mem_data_valid=1 SHALL drive write_data_array=1 in the same cycle (combinational).
REQ-023 On such a cycle, cache_wr_addr SHALL be base+2*rcv_cnt and cache_wr_data SHALL be mem_data_in; rcv_cnt SHALL then increment.
REQ-024 The 8th valid SHALL move FILL->TAG.
REQ-025 TAG SHALL last exactly one cycle with write_tag_array=1 and cache_wr_addr=base, then return to IDLE.
REQ-026 fsm_busy SHALL be 1 in FILL and TAG and 0 in IDLE; it SHALL rise the cycle after the accepted miss.
REQ-027 miss_detected in FILL or TAG SHALL be ignored; a miss in the IDLE cycle right after TAG SHALL be accepted.
REQ-028 mem_data_valid in IDLE or TAG SHALL be ignored: no write, no counter change.
REQ-029 Valids beyond the 8th SHALL be impossible by protocol; the block need not handle them.
REQ-030 When not strobing, write_data_array and write_tag_array SHALL be 0, and cache_wr_data SHALL be 16'h0000.

Reset
REQ-031 rst=0 SHALL immediately force IDLE, clear counters and base, and drive every output 0 / 16'h0000, regardless of clock.
REQ-032 Reset mid-FILL SHALL abort the fill with no tag write; returns arriving after reset release SHALL be ignored per REQ-028.

Verification
REQ-033 Miss at 16'h1236, 4-cycle memory latency -> mem_addr 1230,1232..123E on 8 consecutive cycles; data writes at 1230..123E in order; write_tag_array pulses once with cache_wr_addr=1230; fsm_busy high for 8+4+1 cycles.
REQ-034 Miss at 16'hFFFE -> requests FFF0..FFFE, no wrap to 0000; tag write at FFF0.
REQ-035 Irregular latency (valids with gaps of 0-3 cycles) -> exactly 8 data writes with correct addresses and data; TAG only after the 8th valid.
REQ-036 Second miss at 16'h4000 during a fill, plus a stray valid in IDLE -> no extra requests, no stray write; a miss in the IDLE cycle right after TAG starts a new fill.
REQ-037 rst=0 after 3 returned words -> outputs 0 asynchronously; remaining returns ignored; no tag write; next miss starts from word 0.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Line fill controller: on a miss, reads the eight 16-bit words of a 16 B line, writes each to the data array, then writes the tag once.
// Requests start the cycle after the miss; returns are counted by valid pulse, not cycles; busy stalls the pipeline.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_in,
    output logic        fsm_busy,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    output logic        write_data_array,
    output logic [15:0] cache_wr_addr,
    output logic [15:0] cache_wr_data,
    output logic        write_tag_array
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fillState_t;

    fillState_t  state;
    fillState_t  nextState;
    logic [15:0] base;
    logic [2:0]  issueCnt;
    logic [2:0]  rcvCnt;
    logic        issueDone;
    logic        rcvDone;
    logic        missAccept;
    logic        issuing;
    logic        accepting;

    assign missAccept = (state == IDLE) && miss_detected;
    assign issuing    = (state == FILL) && !issueDone;
    assign accepting  = (state == FILL) && mem_data_valid && !rcvDone;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (missAccept) nextState = FILL;
            FILL: if (accepting && (rcvCnt == 3'd7)) nextState = TAG;
            TAG:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Word offsets are spliced below the line base, so addresses can never carry into the next line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= 16'h0000;
            issueCnt  <= 3'd0;
            rcvCnt    <= 3'd0;
            issueDone <= 1'b0;
            rcvDone   <= 1'b0;
        end else if (missAccept) begin
            base      <= {miss_address[15:4], 4'h0};
            issueCnt  <= 3'd0;
            rcvCnt    <= 3'd0;
            issueDone <= 1'b0;
            rcvDone   <= 1'b0;
        end else begin
            if (issuing) begin
                issueCnt <= issueCnt + 3'd1;
                if (issueCnt == 3'd7) issueDone <= 1'b1;
            end
            if (accepting) begin
                rcvCnt <= rcvCnt + 3'd1;
                if (rcvCnt == 3'd7) rcvDone <= 1'b1;
            end
        end
    end

    always_comb begin
        fsm_busy         = (state != IDLE);
        mem_req          = issuing;
        mem_addr         = base;
        write_data_array = accepting;
        cache_wr_addr    = base;
        cache_wr_data    = 16'h0000;
        write_tag_array  = (state == TAG);
        if (issuing) mem_addr = {base[15:4], issueCnt, 1'b0};
        if (accepting) begin
            cache_wr_addr = {base[15:4], rcvCnt, 1'b0};
            cache_wr_data = mem_data_in;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a randomized memory responder plus a transaction-count reference model checked every cycle.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data_in = 16'h0000;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        write_data_array;
    logic [15:0] cache_wr_addr;
    logic [15:0] cache_wr_data;
    logic        write_tag_array;

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;

    // responder state
    int          dueQ[$];
    logic [15:0] datQ[$];
    int          lastDue = 0;
    int          latMode = 0;
    int          latFix = 4;
    bit          strayEn = 1'b0;

    // reference model: a fill is "active", has issued/received some number of words, then owes one tag write
    bit          mActive = 1'b0;
    bit          mTag = 1'b0;
    int          mIssued = 0;
    int          mRcvd = 0;
    logic [15:0] mBase = 16'h0000;

    // observation logs for the directed scenarios
    logic [15:0] reqLog[$];
    logic [15:0] wrAddrLog[$];
    int          tagCnt = 0;
    logic [15:0] tagAddr = 16'h0000;
    int          busyCnt = 0;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data_valid   (mem_data_valid),
        .mem_data_in      (mem_data_in),
        .fsm_busy         (fsm_busy),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .write_data_array (write_data_array),
        .cache_wr_addr    (cache_wr_addr),
        .cache_wr_data    (cache_wr_data),
        .write_tag_array  (write_tag_array)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else nPass++;
    endtask

    task automatic clearLogs();
        reqLog.delete();
        wrAddrLog.delete();
        tagCnt = 0;
        busyCnt = 0;
    endtask

    // Memory: each request returns later in issue order, one word per cycle at most.
    always @(negedge clk) begin
        int due;
        if (mem_req) begin
            due = cyc + ((latMode == 0) ? latFix : int'($urandom_range(1, 4)));
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            dueQ.push_back(due);
            datQ.push_back(16'($urandom));
        end
        mem_data_valid = 1'b0;
        mem_data_in    = 16'($urandom);
        if (dueQ.size() > 0 && dueQ[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_data_in    = datQ.pop_front();
            void'(dueQ.pop_front());
        end else if (strayEn && dueQ.size() == 0 && (!fsm_busy || write_tag_array)
                     && $urandom_range(0, 1) == 1) begin
            mem_data_valid = 1'b1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mActive = 1'b0;
            mTag    = 1'b0;
            mIssued = 0;
            mRcvd   = 0;
            mBase   = 16'h0000;
        end else if (!mActive) begin
            if (miss_detected) begin
                mActive = 1'b1;
                mBase   = miss_address & 16'hFFF0;
                mIssued = 0;
                mRcvd   = 0;
            end
        end else if (mTag) begin
            mTag    = 1'b0;
            mActive = 1'b0;
        end else begin
            if (mIssued < 8) mIssued++;
            if (mem_data_valid) begin
                mRcvd++;
                if (mRcvd == 8) mTag = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic expReq;
        logic expWr;
        #2;
        expReq = mActive && !mTag && (mIssued < 8);
        expWr  = mActive && !mTag && mem_data_valid;
        chk("busy", {15'h0, fsm_busy}, {15'h0, mActive});
        chk("mem_req", {15'h0, mem_req}, {15'h0, expReq});
        chk("mem_addr", mem_addr, expReq ? mBase + 16'(2 * mIssued) : mBase);
        chk("wr_data_strobe", {15'h0, write_data_array}, {15'h0, expWr});
        chk("wr_data", cache_wr_data, expWr ? mem_data_in : 16'h0000);
        chk("tag_strobe", {15'h0, write_tag_array}, {15'h0, mTag});
        if (expWr) chk("wr_addr", cache_wr_addr, mBase + 16'(2 * mRcvd));
        if (mTag) chk("tag_addr", cache_wr_addr, mBase);
        if (!rst) chk("rst_wr_addr", cache_wr_addr, 16'h0000);
        if (mem_req) reqLog.push_back(mem_addr);
        if (write_data_array) wrAddrLog.push_back(cache_wr_addr);
        if (write_tag_array) begin
            tagCnt++;
            tagAddr = cache_wr_addr;
        end
        if (fsm_busy) busyCnt++;
    end

    task automatic doMiss(input logic [15:0] a);
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = a;
        @(negedge clk);
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        @(negedge clk);
        while (fsm_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, {15'h0, fsm_busy}, 16'h0000);
        #3;
    endtask

    function automatic logic [15:0] qAt(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'hxxxx;
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_busy", {15'h0, fsm_busy}, 16'h0000);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk("reset_wr_data", cache_wr_data, 16'h0000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // fixed 4-cycle latency, miss inside a line
        latMode = 0;
        latFix  = 4;
        clearLogs();
        doMiss(16'h1236);
        waitIdle("A_timeout");
        chk("A_req_count", 16'(reqLog.size()), 16'd8);
        chk("A_wr_count", 16'(wrAddrLog.size()), 16'd8);
        for (int i = 0; i < 8; i++) begin
            chk("A_req_addr", qAt(reqLog, i), 16'h1230 + 16'(2 * i));
            chk("A_wr_addr", qAt(wrAddrLog, i), 16'h1230 + 16'(2 * i));
        end
        chk("A_tag_count", 16'(tagCnt), 16'd1);
        chk("A_tag_addr", tagAddr, 16'h1230);
        chk("A_busy_cycles", 16'(busyCnt), 16'd13);

        // top of the address space must not wrap
        clearLogs();
        doMiss(16'hFFFE);
        waitIdle("B_timeout");
        chk("B_req_first", qAt(reqLog, 0), 16'hFFF0);
        chk("B_req_last", qAt(reqLog, 7), 16'hFFFE);
        chk("B_req_count", 16'(reqLog.size()), 16'd8);
        chk("B_tag_addr", tagAddr, 16'hFFF0);

        // second miss during a fill, miss right after TAG, stray valids while idle
        latMode = 1;
        clearLogs();
        doMiss(16'h2000);
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h4000;
        @(negedge clk);
        miss_detected = 1'b0;
        n = 0;
        while (!write_tag_array && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("D_tag_seen", {15'h0, write_tag_array}, 16'h0001);
        chk("D_req_count", 16'(reqLog.size()), 16'd8);
        chk("D_req_first", qAt(reqLog, 0), 16'h2000);
        chk("D_tag_addr", tagAddr, 16'h2000);
        clearLogs();
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = 16'h5556;
        @(negedge clk);
        miss_detected = 1'b0;
        waitIdle("D2_timeout");
        chk("D2_req_first", qAt(reqLog, 0), 16'h5550);
        chk("D2_req_count", 16'(reqLog.size()), 16'd8);
        chk("D2_tag_addr", tagAddr, 16'h5550);
        clearLogs();
        strayEn = 1'b1;
        repeat (20) @(negedge clk);
        strayEn = 1'b0;
        #3;
        chk("D_stray_writes", 16'(wrAddrLog.size()), 16'd0);
        chk("D_stray_reqs", 16'(reqLog.size()), 16'd0);

        // reset after three returned words
        latMode = 0;
        latFix  = 3;
        clearLogs();
        doMiss(16'h3456);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            #3;
            if (wrAddrLog.size() >= 3) break;
            n++;
        end
        chk("E_three_words", 16'(wrAddrLog.size()), 16'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("E_async_busy", {15'h0, fsm_busy}, 16'h0000);
        chk("E_async_req", {15'h0, mem_req}, 16'h0000);
        chk("E_async_mem_addr", mem_addr, 16'h0000);
        chk("E_async_wr", {15'h0, write_data_array}, 16'h0000);
        chk("E_async_wr_addr", cache_wr_addr, 16'h0000);
        chk("E_async_wr_data", cache_wr_data, 16'h0000);
        chk("E_async_tag", {15'h0, write_tag_array}, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (dueQ.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #3;
        chk("E_drained", 16'(dueQ.size()), 16'd0);
        chk("E_no_more_writes", 16'(wrAddrLog.size()), 16'd3);
        chk("E_no_tag", 16'(tagCnt), 16'd0);
        latMode = 1;
        clearLogs();
        doMiss(16'h7772);
        waitIdle("E2_timeout");
        chk("E2_req_first", qAt(reqLog, 0), 16'h7770);
        chk("E2_wr_first", qAt(wrAddrLog, 0), 16'h7770);
        chk("E2_wr_count", 16'(wrAddrLog.size()), 16'd8);
        chk("E2_tag_addr", tagAddr, 16'h7770);

        // random misses, irregular latency, stray valids in IDLE/TAG
        strayEn = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            miss_detected = ($urandom_range(0, 4) == 0);
            miss_address  = 16'($urandom);
        end
        miss_detected = 1'b0;
        waitIdle("R_timeout");
        strayEn = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", nPass, nChecks);
        $fatal(1);
    end

endmodule
